nv_nvdla_mcif_write_cq: RTL and testbench

NV_NVDLA_MCIF_WRITE_CQ -- requirements
Module: nv_nvdla_mcif_write_cq

---
 rtl/nv_nvdla_mcif_write_cq_pkg.sv | 17 +
 rtl/nv_nvdla_mcif_write_cq_fifo.sv | 51 +++++
 rtl/nv_nvdla_mcif_write_cq.sv | 85 ++++++++
 tb/tb_nv_nvdla_mcif_write_cq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_mcif_write_cq_pkg.sv
// Shared defaults and entry layout for the write completion queue.
package nv_nvdla_mcif_write_cq_pkg;

    localparam int CQ_THREADS = 5;
    localparam int CQ_DEPTH   = 8;
    localparam int CQ_PD_W    = 3;

    localparam int LEN_MSB = 2;
    localparam int LEN_LSB = 1;
    localparam int ACK_BIT = 0;

    typedef struct packed {
        logic [LEN_MSB-LEN_LSB:0] len;
        logic                     require_ack;
    } cq_entry_t;

endpackage

// File: rtl/nv_nvdla_mcif_write_cq_fifo.sv
// One per-thread in-order FIFO of DEPTH x PD_W entries, pointers wrap modulo DEPTH.
// Latency: a pushed entry shows on head_pd/!empty one cycle later; no bypass.
// Backpressure: push is ignored when full, pop is ignored when empty.
module nv_nvdla_mcif_write_cq_fifo #(
    parameter int DEPTH = 8,
    parameter int PD_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [PD_W-1:0]          push_pd,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [PD_W-1:0]          head_pd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PD_W-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_pd = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is deliberately not reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= push_pd;
    end

endmodule

// File: rtl/nv_nvdla_mcif_write_cq.sv
// Per-AXI-ID write completion queue: one FIFO per thread, plus idle and bad-ID flags.
// Latency: push visible at the thread head one cycle after acceptance; cq_idle registered.
// Backpressure: cq_wr_prdy drops only for a full target thread; illegal IDs are always accepted.
module nv_nvdla_mcif_write_cq
    import nv_nvdla_mcif_write_cq_pkg::*;
#(
    parameter int THREADS = CQ_THREADS,
    parameter int DEPTH   = CQ_DEPTH,
    parameter int PD_W    = CQ_PD_W
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    cq_wr_pvld,
    output logic                    cq_wr_prdy,
    input  logic [2:0]              cq_wr_thread_id,
    input  logic [PD_W-1:0]         cq_wr_pd,
    output logic [THREADS-1:0]      cq_rd_pvld,
    output logic [THREADS*PD_W-1:0] cq_rd_pd,
    input  logic [THREADS-1:0]      cq_rd_prdy,
    output logic                    cq_idle,
    output logic                    cq_err_id
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [THREADS-1:0] full;
    logic [THREADS-1:0] empty;
    logic [THREADS-1:0] push_sel;
    logic [THREADS-1:0] pop_sel;
    logic [THREADS-1:0] nxt_zero;
    logic [CW-1:0]      count [THREADS];
    logic               id_legal;

    assign id_legal   = (int'(cq_wr_thread_id) < THREADS);
    assign pop_sel    = cq_rd_prdy & ~empty;
    assign cq_rd_pvld = ~empty;

    // Fullness is judged before this cycle's pop, so a full thread refuses even while draining.
    always_comb begin
        cq_wr_prdy = 1'b1;
        push_sel   = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (int'(cq_wr_thread_id) == i) begin
                cq_wr_prdy  = ~full[i];
                push_sel[i] = cq_wr_pvld & ~full[i];
            end
        end
    end

    always_comb begin
        nxt_zero = '0;
        for (int i = 0; i < THREADS; i++) begin
            nxt_zero[i] = ~push_sel[i] &
                          ((count[i] == '0) || ((count[i] == CW'(1)) && pop_sel[i]));
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cq_idle   <= 1'b1;
            cq_err_id <= 1'b0;
        end else begin
            cq_idle   <= &nxt_zero;
            cq_err_id <= cq_err_id | (cq_wr_pvld & ~id_legal);
        end
    end

    for (genvar g = 0; g < THREADS; g++) begin : g_thread
        nv_nvdla_mcif_write_cq_fifo #(
            .DEPTH (DEPTH),
            .PD_W  (PD_W)
        ) u_fifo (
            .clk     (nvdla_core_clk),
            .rst     (nvdla_core_rst),
            .push    (push_sel[g]),
            .push_pd (cq_wr_pd),
            .pop     (cq_rd_prdy[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .count   (count[g]),
            .head_pd (cq_rd_pd[g*PD_W +: PD_W])
        );
    end

endmodule

// File: tb/tb_nv_nvdla_mcif_write_cq.sv
// Randomized and directed checks of the write completion queue against a queue-based model.
module tb_nv_nvdla_mcif_write_cq;

    localparam int TH = 5;
    localparam int DP = 8;
    localparam int PW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_pvld = 1'b0;
    logic              wr_prdy;
    logic [2:0]        wr_id = '0;
    logic [PW-1:0]     wr_pd = '0;
    logic [TH-1:0]     rd_pvld;
    logic [TH*PW-1:0]  rd_pd;
    logic [TH-1:0]     rd_prdy = '0;
    logic              idle;
    logic              err_id;

    always #5 clk = ~clk;

    nv_nvdla_mcif_write_cq #(.THREADS(TH), .DEPTH(DP), .PD_W(PW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rst  (rst),
        .cq_wr_pvld      (wr_pvld),
        .cq_wr_prdy      (wr_prdy),
        .cq_wr_thread_id (wr_id),
        .cq_wr_pd        (wr_pd),
        .cq_rd_pvld      (rd_pvld),
        .cq_rd_pd        (rd_pd),
        .cq_rd_prdy      (rd_prdy),
        .cq_idle         (idle),
        .cq_err_id       (err_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] mq [TH][$];
    logic          m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [TH-1:0] ep;
        bit all_empty;
        ep = '0;
        all_empty = 1'b1;
        for (int i = 0; i < TH; i++) begin
            if (mq[i].size() != 0) begin
                ep[i] = 1'b1;
                all_empty = 1'b0;
                chk($sformatf("head_pd[%0d]", i), 32'(rd_pd[i*PW +: PW]), 32'(mq[i][0]));
            end
        end
        chk("rd_pvld", 32'(rd_pvld), 32'(ep));
        chk("idle", 32'(idle), 32'(all_empty));
        chk("err_id", 32'(err_id), 32'(m_err));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit exp_rdy;
        #1;
        exp_rdy = (wr_id >= TH) ? 1'b1 : (mq[wr_id].size() < DP);
        if (!rst) chk("wr_prdy", 32'(wr_prdy), 32'(exp_rdy));
        if (rst) begin
            for (int i = 0; i < TH; i++) mq[i].delete();
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < TH; i++)
                if (rd_prdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
            if (wr_pvld && exp_rdy) begin
                if (wr_id >= TH) m_err = 1'b1;
                else mq[wr_id].push_back(wr_pd);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic push(input int id, input logic [PW-1:0] pd);
        wr_pvld = 1'b1;
        wr_id   = 3'(id);
        wr_pd   = pd;
        cycle();
        wr_pvld = 1'b0;
    endtask

    task automatic drain();
        wr_pvld = 1'b0;
        rd_prdy = '1;
        for (int k = 0; k < DP + 2; k++) cycle();
        rd_prdy = '0;
    endtask

    initial begin
        logic [PW-1:0] hold;
        logic [TH-1:0] pv_before;
        int occ;

        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_pvld", 32'(rd_pvld), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_err", 32'(err_id), 32'h0);

        // Single push becomes visible one cycle later.
        push(2, 3'b101);
        chk("t2_pvld", 32'(rd_pvld), 32'h04);
        chk("t2_pd", 32'(rd_pd[8:6]), 32'h5);
        chk("t2_idle", 32'(idle), 32'h0);
        drain();

        // Fill thread 0, other threads still accept.
        for (int k = 0; k < DP; k++) push(0, PW'($urandom));
        wr_pvld = 1'b1; wr_id = 3'd0; wr_pd = 3'd6;
        #1 chk("t0_full_rdy", 32'(wr_prdy), 32'h0);
        cycle();
        wr_id = 3'd4; wr_pd = 3'd2;
        #1 chk("t4_rdy", 32'(wr_prdy), 32'h1);
        cycle();
        wr_id = 3'd0; wr_pd = 3'd3; rd_prdy = 5'b00001;
        #1 chk("t0_full_pop_rdy", 32'(wr_prdy), 32'h0);
        cycle();
        rd_prdy = '0;
        #1 chk("t0_after_pop_rdy", 32'(wr_prdy), 32'h1);
        cycle();
        wr_pvld = 1'b0;
        drain();

        // Steady push+pop on thread 1 with three entries resident.
        for (int k = 0; k < 3; k++) push(1, PW'($urandom));
        wr_pvld = 1'b1; wr_id = 3'd1; rd_prdy = 5'b00010;
        for (int k = 0; k < 20; k++) begin
            wr_pd = PW'($urandom);
            cycle();
        end
        wr_pvld = 1'b0;
        occ = 0;
        for (int k = 0; k < 5; k++) begin
            if (rd_pvld[1]) occ++;
            cycle();
        end
        chk("t1_occupancy", 32'(occ), 32'd3);
        rd_prdy = '0;
        drain();

        // Head held stable without pop; pop on empty thread is harmless.
        push(3, 3'b110);
        hold = rd_pd[11:9];
        rd_prdy = 5'b10000;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_stable", 32'(rd_pd[11:9]), 32'h6);
            chk("t3_hold", 32'(rd_pd[11:9]), 32'(hold));
            chk("t3_t4_pvld", 32'(rd_pvld), 32'h08);
        end
        rd_prdy = '0;
        drain();

        // Illegal thread id.
        pv_before = rd_pvld;
        wr_pvld = 1'b1; wr_id = 3'd6; wr_pd = 3'd7;
        #1 chk("bad_id_rdy", 32'(wr_prdy), 32'h1);
        cycle();
        wr_pvld = 1'b0;
        chk("bad_id_err", 32'(err_id), 32'h1);
        chk("bad_id_pvld", 32'(rd_pvld), 32'(pv_before));
        for (int k = 0; k < 3; k++) cycle();
        chk("bad_id_sticky", 32'(err_id), 32'h1);

        // Reset mid-operation with a push pending.
        for (int k = 0; k < 4; k++) push(k, PW'(k + 1));
        wr_pvld = 1'b1; wr_id = 3'd4; wr_pd = 3'd5; rst = 1'b1;
        cycle();
        rst = 1'b0; wr_pvld = 1'b0;
        chk("mid_rst_pvld", 32'(rd_pvld), 32'h0);
        chk("mid_rst_idle", 32'(idle), 32'h1);
        chk("mid_rst_err", 32'(err_id), 32'h0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            rst     = ($urandom_range(0, 149) == 0);
            wr_pvld = ($urandom_range(0, 3) != 0);
            wr_id   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                   : 3'($urandom_range(0, 4));
            wr_pd   = PW'($urandom);
            for (int i = 0; i < TH; i++) rd_prdy[i] = ($urandom_range(0, 2) == 0);
            cycle();
        end
        rst = 1'b0; wr_pvld = 1'b0; rd_prdy = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
